// File: rtl/pit_pkg.sv
// Shared definitions for the 8254 bus sequencer.
//   - host op encodings and {A1,A0} constants
//   - counter-latch command builder and per-op byte count
//   - sequencer state enum
package pit_pkg;

    typedef enum logic [1:0] {
        OP_WRITE_CW = 2'd0,
        OP_LOAD16   = 2'd1,
        OP_READ16   = 2'd2,
        OP_WRITE8   = 2'd3
    } pit_op_e;

    localparam logic [1:0] A_CW        = 2'b11;
    localparam logic [1:0] SEL_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RESP
    } pit_state_e;

    // Counter-latch control word: SC1:SC0 = sel, RW = 00, mode/BCD = 0.
    function automatic logic [7:0] latch_cmd(input logic [1:0] sel);
        return {sel, 2'b00, 4'b0000};
    endfunction

    // Index of the final bus cycle of an op (bytes - 1).
    function automatic logic [1:0] last_byte(input pit_op_e op);
        case (op)
            OP_LOAD16: return 2'd1;
            OP_READ16: return 2'd2;
            default:   return 2'd0;
        endcase
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pit_phase_timer.sv
// Loadable down-counter timing one bus phase (SETUP, STROBE or HOLD).
//   load/load_val : restart the phase; load_val is (phase length - 1)
//   count         : cycles left in the phase after this one
//   done          : last cycle of the phase (count reached zero)
module pit_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         done
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - W'(1);
    end

    assign done = (count == '0);

endmodule

// File: rtl/pit_bus_master.sv
// Host-command sequencer driving 8254 bus cycles.
//   cmd_*   : single-cycle host command (valid/ready handshake)
//   rsp_*   : one-cycle completion pulse with READ16 data and select error
//   pit_*   : registered 8254 bus (CS_n, RD_n, WR_n, {A1,A0}, data + drive enable)
// Bus outputs are registered from the current state, so each phase appears on
// the pins one cycle after the state register enters it.
module pit_bus_master
    import pit_pkg::*;
#(
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_sel,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        pit_cs_n,
    output logic        pit_rd_n,
    output logic        pit_wr_n,
    output logic [1:0]  pit_a,
    output logic [7:0]  pit_d_out,
    output logic        pit_d_oe,
    input  logic [7:0]  pit_d_in
);

    localparam int CW = $clog2(max3(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES) + 1);
    localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] LD_PULSE = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYCLES - 1);

    pit_state_e  state, next;
    logic [1:0]  byte_idx;
    logic        byte_inc;
    pit_op_e     lat_op;
    logic [1:0]  lat_sel;
    logic [15:0] lat_data;
    logic        lat_err;
    logic        rd_sample, rd_msb;

    logic          t_load, t_done;
    logic [CW-1:0] t_val, t_count;

    logic        accept, illegal_in;
    logic        cur_wr;
    logic [1:0]  cur_a;
    logic [7:0]  cur_d;

    assign accept     = cmd_valid && cmd_ready;
    assign illegal_in = (cmd_sel == SEL_ILLEGAL) && (cmd_op != OP_WRITE_CW);

    pit_phase_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (t_val),
        .count    (t_count),
        .done     (t_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next;
    end

    always_comb begin
        next     = state;
        t_load   = 1'b0;
        t_val    = LD_SETUP;
        byte_inc = 1'b0;
        case (state)
            ST_IDLE: if (accept) begin
                if (illegal_in) next = ST_RESP;
                else begin
                    next   = ST_SETUP;
                    t_load = 1'b1;
                end
            end
            ST_SETUP: if (t_done) begin
                next   = ST_STROBE;
                t_load = 1'b1;
                t_val  = LD_PULSE;
            end
            ST_STROBE: if (t_done) begin
                next   = ST_HOLD;
                t_load = 1'b1;
                t_val  = LD_HOLD;
            end
            ST_HOLD: if (t_done) begin
                if (byte_idx == last_byte(lat_op)) next = ST_RESP;
                else begin
                    next     = ST_SETUP;
                    t_load   = 1'b1;
                    byte_inc = 1'b1;
                end
            end
            ST_RESP: next = ST_IDLE;
            default: next = ST_IDLE;
        endcase
    end

    // What the current byte puts on the bus.
    always_comb begin
        cur_wr = 1'b1;
        cur_a  = lat_sel;
        cur_d  = lat_data[7:0];
        case (lat_op)
            OP_WRITE_CW: cur_a = A_CW;
            OP_LOAD16:   if (byte_idx == 2'd1) cur_d = lat_data[15:8];
            OP_READ16:   if (byte_idx == 2'd0) begin
                             cur_a = A_CW;
                             cur_d = latch_cmd(lat_sel);
                         end else begin
                             cur_wr = 1'b0;
                             cur_d  = 8'h00;
                         end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx <= 2'd0;
            lat_op   <= OP_WRITE_CW;
            lat_sel  <= 2'd0;
            lat_data <= 16'h0000;
            lat_err  <= 1'b0;
        end else if (accept) begin
            byte_idx <= 2'd0;
            lat_op   <= pit_op_e'(cmd_op);
            lat_sel  <= cmd_sel;
            lat_data <= cmd_data;
            lat_err  <= illegal_in;
        end else if (byte_inc) begin
            byte_idx <= byte_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= 16'h0000;
            rd_sample <= 1'b0;
            rd_msb    <= 1'b0;
            pit_cs_n  <= 1'b1;
            pit_rd_n  <= 1'b1;
            pit_wr_n  <= 1'b1;
            pit_a     <= 2'b00;
            pit_d_out <= 8'h00;
            pit_d_oe  <= 1'b0;
        end else begin
            cmd_ready <= (next == ST_IDLE);
            rsp_valid <= (state == ST_RESP);
            rsp_err   <= (state == ST_RESP) && lat_err;
            // RD_n rises on the edge after the last STROBE state cycle; that
            // edge closes the last low bus cycle and is where data is taken.
            rd_sample <= (state == ST_STROBE) && t_done && !cur_wr;
            rd_msb    <= (byte_idx == 2'd2);
            if (accept)
                rsp_data <= 16'h0000;
            else if (rd_sample) begin
                if (rd_msb) rsp_data[15:8] <= pit_d_in;
                else        rsp_data[7:0]  <= pit_d_in;
            end
            case (state)
                ST_SETUP: begin
                    // First SETUP cycle of a follow-on byte doubles as the CS gap.
                    pit_cs_n  <= (byte_idx != 2'd0) && (t_count == LD_SETUP);
                    pit_rd_n  <= 1'b1;
                    pit_wr_n  <= 1'b1;
                    pit_a     <= cur_a;
                    pit_d_out <= cur_d;
                    pit_d_oe  <= cur_wr;
                end
                ST_STROBE: begin
                    pit_cs_n <= 1'b0;
                    pit_wr_n <= !cur_wr;
                    pit_rd_n <= cur_wr;
                end
                ST_HOLD: begin
                    pit_rd_n <= 1'b1;
                    pit_wr_n <= 1'b1;
                end
                default: begin
                    pit_cs_n <= 1'b1;
                    pit_rd_n <= 1'b1;
                    pit_wr_n <= 1'b1;
                    pit_d_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pit_bus_master.sv
// Bench for pit_bus_master: two instances (default timing and 2/3/2 timing),
// a trace-building reference model, a simple 8254 read-data responder and
// random plus directed commands.
module tb_pit_bus_master;

    typedef struct {
        logic        cs_n, rd_n, wr_n;
        logic [1:0]  a;
        logic [7:0]  d;
        logic        oe, ready, rv, err;
        logic [15:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic        cmd_valid[2], cmd_ready[2], rsp_valid[2], rsp_err[2];
    logic        cs_n[2], rd_n[2], wr_n[2], d_oe[2];
    logic [1:0]  cmd_op[2], cmd_sel[2], pit_a[2];
    logic [15:0] cmd_data[2], rsp_data[2];
    logic [7:0]  d_out[2], d_in[2];

    always #5 clk = ~clk;

    pit_bus_master dut0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
        .cmd_sel(cmd_sel[0]), .cmd_data(cmd_data[0]),
        .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
        .pit_cs_n(cs_n[0]), .pit_rd_n(rd_n[0]), .pit_wr_n(wr_n[0]), .pit_a(pit_a[0]),
        .pit_d_out(d_out[0]), .pit_d_oe(d_oe[0]), .pit_d_in(d_in[0])
    );

    pit_bus_master #(.SETUP_CYCLES(2), .PULSE_CYCLES(3), .HOLD_CYCLES(2)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
        .cmd_sel(cmd_sel[1]), .cmd_data(cmd_data[1]),
        .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
        .pit_cs_n(cs_n[1]), .pit_rd_n(rd_n[1]), .pit_wr_n(wr_n[1]), .pit_a(pit_a[1]),
        .pit_d_out(d_out[1]), .pit_d_oe(d_oe[1]), .pit_d_in(d_in[1])
    );

    int n_cmp = 0, n_fail = 0;
    exp_t q0[$], q1[$];
    logic [7:0] rq0[$], rq1[$];
    int rcnt[2];
    logic [15:0] mrd[2];
    bit rnd_mode, rst_chk;

    logic pend[2];
    logic [1:0] p_op[2], p_sel[2];
    logic [15:0] p_data[2];
    logic [7:0] p_lsb[2], p_msb[2];

    int ocnt[2], owr[2], ord[2], ocsi[2], olat[2];
    logic [7:0] ofirst_wd[2], olast_wd[2];
    logic owd_seen[2], oprev_cs[2], odone[2], oerr[2];
    logic [15:0] ordata[2];

    function automatic int s_of(int k); return (k == 0) ? 1 : 2; endfunction
    function automatic int p_of(int k); return (k == 0) ? 2 : 3; endfunction
    function automatic int h_of(int k); return (k == 0) ? 1 : 2; endfunction

    function automatic exp_t mk(input logic cs, input logic rd, input logic wr,
                                input logic [1:0] a, input logic [7:0] d, input logic oe,
                                input logic rdy, input logic rv, input logic er,
                                input logic [15:0] rdat);
        exp_t e;
        e.cs_n = cs; e.rd_n = rd; e.wr_n = wr; e.a = a; e.d = d; e.oe = oe;
        e.ready = rdy; e.rv = rv; e.err = er; e.rdata = rdat;
        return e;
    endfunction

    function automatic int qsize(int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic cmp(input string nm, input int k, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t got=%h exp=%h", nm, k, $time, got, exp);
        end
    endtask

    task automatic push_e(input int k, input exp_t e);
        if (k == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // Expected per-cycle view, starting with the cycle right after acceptance.
    task automatic push_trace(input int k, input logic [1:0] op, input logic [1:0] sel,
                              input logic [15:0] data, input logic [7:0] lsb, input logic [7:0] msb);
        int n;
        logic [15:0] rd;
        logic wr;
        logic [1:0] a;
        logic [7:0] d;
        rd = 16'h0000;
        push_e(k, mk(1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, rd));
        if (sel == 2'd3 && op != 2'd0) begin
            push_e(k, mk(1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, rd));
            mrd[k] = rd;
            return;
        end
        n = (op == 2'd1) ? 2 : (op == 2'd2) ? 3 : 1;
        for (int b = 0; b < n; b++) begin
            wr = 1'b1; a = sel; d = data[7:0];
            if (op == 2'd0) a = 2'd3;
            if (op == 2'd1 && b == 1) d = data[15:8];
            if (op == 2'd2) begin
                if (b == 0) begin a = 2'd3; d = {sel, 6'b000000}; end
                else begin wr = 1'b0; d = 8'h00; end
            end
            for (int s = 0; s < s_of(k); s++)
                push_e(k, mk((b > 0) && (s == 0), 1'b1, 1'b1, a, d, wr, 1'b0, 1'b0, 1'b0, rd));
            for (int p = 0; p < p_of(k); p++)
                push_e(k, mk(1'b0, wr, !wr, a, d, wr, 1'b0, 1'b0, 1'b0, rd));
            for (int h = 0; h < h_of(k); h++) begin
                if (!wr && h == 0) rd = (b == 1) ? {rd[15:8], lsb} : {msb, rd[7:0]};
                push_e(k, mk(1'b0, 1'b1, 1'b1, a, d, wr, 1'b0, 1'b0, 1'b0, rd));
            end
        end
        push_e(k, mk(1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, rd));
        mrd[k] = rd;
    endtask

    task automatic check(input int k);
        exp_t e;
        if (qsize(k) != 0) begin
            if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
        end else
            e = mk(1'b1, 1'b1, 1'b1, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, mrd[k]);
        cmp("cs_n", k, 16'(cs_n[k]), 16'(e.cs_n));
        cmp("rd_n", k, 16'(rd_n[k]), 16'(e.rd_n));
        cmp("wr_n", k, 16'(wr_n[k]), 16'(e.wr_n));
        cmp("d_oe", k, 16'(d_oe[k]), 16'(e.oe));
        cmp("cmd_ready", k, 16'(cmd_ready[k]), 16'(e.ready));
        cmp("rsp_valid", k, 16'(rsp_valid[k]), 16'(e.rv));
        cmp("rsp_err", k, 16'(rsp_err[k]), 16'(e.err));
        cmp("rsp_data", k, rsp_data[k], e.rdata);
        cmp("oe_during_rd", k, 16'(d_oe[k] & ~rd_n[k]), 16'h0000);
        if (!e.cs_n) cmp("pit_a", k, 16'(pit_a[k]), 16'(e.a));
        if (e.oe)    cmp("d_out", k, 16'(d_out[k]), 16'(e.d));
        if (rst_chk) begin
            cmp("rst_a", k, 16'(pit_a[k]), 16'h0000);
            cmp("rst_dout", k, 16'(d_out[k]), 16'h0000);
        end
        ocnt[k]++;
        if (!wr_n[k]) begin
            owr[k]++;
            if (!owd_seen[k]) begin ofirst_wd[k] = d_out[k]; owd_seen[k] = 1'b1; end
            olast_wd[k] = d_out[k];
        end
        if (!rd_n[k]) ord[k]++;
        if (!cs_n[k] && oprev_cs[k]) ocsi[k]++;
        oprev_cs[k] = cs_n[k];
        if (rsp_valid[k]) begin
            olat[k] = ocnt[k]; ordata[k] = rsp_data[k]; oerr[k] = rsp_err[k]; odone[k] = 1'b1;
        end
    endtask

    // 8254 read side: garbage until the final low cycle of RD_n, then the byte.
    task automatic chip(input int k);
        logic [7:0] b;
        b = 8'h00;
        if (k == 0 && rq0.size() > 0) b = rq0[0];
        if (k == 1 && rq1.size() > 0) b = rq1[0];
        if (!rd_n[k]) begin
            rcnt[k]++;
            d_in[k] = (rcnt[k] == p_of(k)) ? b : ~b;
        end else begin
            if (rcnt[k] > 0) begin
                if (k == 0 && rq0.size() > 0) void'(rq0.pop_front());
                if (k == 1 && rq1.size() > 0) void'(rq1.pop_front());
            end
            rcnt[k] = 0;
            d_in[k] = 8'($urandom);
        end
    endtask

    task automatic issue(input int k, input logic [1:0] op, input logic [1:0] sel,
                         input logic [15:0] data, input logic [7:0] lsb, input logic [7:0] msb);
        cmd_valid[k] = 1'b1; cmd_op[k] = op; cmd_sel[k] = sel; cmd_data[k] = data;
        push_trace(k, op, sel, data, lsb, msb);
        if (op == 2'd2 && sel != 2'd3) begin
            if (k == 0) begin rq0.push_back(lsb); rq0.push_back(msb); end
            else begin rq1.push_back(lsb); rq1.push_back(msb); end
        end
        ocnt[k] = -1; owr[k] = 0; ord[k] = 0; ocsi[k] = 0; owd_seen[k] = 1'b0;
        oprev_cs[k] = 1'b1; odone[k] = 1'b0;
    endtask

    task automatic drive(input int k);
        if (rst_chk || qsize(k) != 0) begin
            // Busy (or in reset): host noise that must be ignored.
            cmd_valid[k] = 1'($urandom_range(0, 1));
            cmd_op[k] = 2'($urandom_range(0, 3));
            cmd_sel[k] = 2'($urandom_range(0, 3));
            cmd_data[k] = 16'($urandom);
        end else if (pend[k]) begin
            issue(k, p_op[k], p_sel[k], p_data[k], p_lsb[k], p_msb[k]);
            pend[k] = 1'b0;
        end else if (rnd_mode && $urandom_range(0, 3) != 0)
            issue(k, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 16'($urandom),
                  8'($urandom), 8'($urandom));
        else
            cmd_valid[k] = 1'b0;
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check(k);
            chip(k);
            drive(k);
        end
    endtask

    task automatic run_cmd(input int k, input logic [1:0] op, input logic [1:0] sel,
                           input logic [15:0] data, input logic [7:0] lsb, input logic [7:0] msb);
        p_op[k] = op; p_sel[k] = sel; p_data[k] = data; p_lsb[k] = lsb; p_msb[k] = msb;
        pend[k] = 1'b1; odone[k] = 1'b0;
        for (int i = 0; i < 100 && !odone[k]; i++) cycle();
        cmp("rsp_timeout", k, 16'(odone[k]), 16'h0001);
    endtask

    task automatic clear_model();
        q0.delete(); q1.delete(); rq0.delete(); rq1.delete();
        for (int k = 0; k < 2; k++) begin
            rcnt[k] = 0; mrd[k] = 16'h0000; pend[k] = 1'b0; cmd_valid[k] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; rst_chk = 1'b1; rnd_mode = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cmd_op[k] = 2'd0; cmd_sel[k] = 2'd0; cmd_data[k] = 16'h0; d_in[k] = 8'h0;
            oprev_cs[k] = 1'b1; odone[k] = 1'b0; ocnt[k] = 0;
        end
        clear_model();
        repeat (6) cycle();
        #1 rst_n = 1'b1; rst_chk = 1'b0; cmd_valid[0] = 1'b0; cmd_valid[1] = 1'b0;
        repeat (2) cycle();

        // Directed commands with hand-derived expectations.
        run_cmd(0, 2'd0, 2'd0, 16'h0034, 8'h00, 8'h00);
        cmp("cw_latency", 0, 16'(olat[0]), 16'd5);
        cmp("cw_wr_low", 0, 16'(owr[0]), 16'd2);
        cmp("cw_data", 0, 16'(ofirst_wd[0]), 16'h0034);
        cmp("cw_err", 0, 16'(oerr[0]), 16'h0000);
        cmp("cw_cs_runs", 0, 16'(ocsi[0]), 16'd1);

        run_cmd(0, 2'd1, 2'd1, 16'h1234, 8'h00, 8'h00);
        cmp("ld_latency", 0, 16'(olat[0]), 16'd9);
        cmp("ld_cs_runs", 0, 16'(ocsi[0]), 16'd2);
        cmp("ld_wr_low", 0, 16'(owr[0]), 16'd4);
        cmp("ld_lsb", 0, 16'(ofirst_wd[0]), 16'h0034);
        cmp("ld_msb", 0, 16'(olast_wd[0]), 16'h0012);

        run_cmd(0, 2'd2, 2'd2, 16'h0000, 8'hCD, 8'hAB);
        cmp("rd_latency", 0, 16'(olat[0]), 16'd13);
        cmp("rd_data", 0, ordata[0], 16'hABCD);
        cmp("rd_latch_cw", 0, 16'(ofirst_wd[0]), 16'h0080);
        cmp("rd_rd_low", 0, 16'(ord[0]), 16'd4);
        cmp("rd_cs_runs", 0, 16'(ocsi[0]), 16'd3);

        run_cmd(0, 2'd1, 2'd3, 16'hBEEF, 8'h00, 8'h00);
        cmp("ill_latency", 0, 16'(olat[0]), 16'd1);
        cmp("ill_err", 0, 16'(oerr[0]), 16'h0001);
        cmp("ill_cs_runs", 0, 16'(ocsi[0]), 16'd0);
        cmp("ill_data", 0, ordata[0], 16'h0000);

        run_cmd(1, 2'd3, 2'd0, 16'h00A5, 8'h00, 8'h00);
        cmp("w8_slow_latency", 1, 16'(olat[1]), 16'd8);
        cmp("w8_slow_wr_low", 1, 16'(owr[1]), 16'd3);
        cmp("w8_slow_data", 1, 16'(ofirst_wd[1]), 16'h00A5);

        // Random traffic, back-to-back issue and busy-time noise.
        rnd_mode = 1'b1;
        repeat (600) cycle();
        rnd_mode = 1'b0;
        for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) cycle();
        cmp("drain", 0, 16'(q0.size() + q1.size()), 16'd0);

        // Asynchronous reset while WR_n is low.
        p_op[0] = 2'd0; p_sel[0] = 2'd0; p_data[0] = 16'h005A; pend[0] = 1'b1;
        for (int i = 0; i < 20 && wr_n[0] !== 1'b0; i++) cycle();
        cmp("wr_low_seen", 0, 16'(wr_n[0]), 16'h0000);
        #1 rst_n = 1'b0;
        #1;
        cmp("async_wr_n", 0, 16'(wr_n[0]), 16'h0001);
        cmp("async_cs_n", 0, 16'(cs_n[0]), 16'h0001);
        cmp("async_d_oe", 0, 16'(d_oe[0]), 16'h0000);
        clear_model();
        rst_chk = 1'b1;
        repeat (2) cycle();
        #1 rst_n = 1'b1; rst_chk = 1'b0; cmd_valid[0] = 1'b0; cmd_valid[1] = 1'b0;
        repeat (12) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
